// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel prescaler, h/v position counters,
// zero-skew registered syncs/blanking, line/frame strobes and a frame counter.
module video_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned PIX_DIV   = 1,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned FRAME_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               restart,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               pix_ce,
  output logic               line_end,
  output logic               frame_end,
  output logic [FRAME_W-1:0] frame
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [POS_W-1:0]   h_nxt, v_nxt;
  logic [FRAME_W-1:0] f_nxt;

  function automatic logic in_span(input logic [POS_W-1:0] p,
                                   input int unsigned lo, input int unsigned len);
    return (p >= POS_W'(lo)) && (p <= POS_W'(lo + len - 1));
  endfunction

  // Strobes are forced low while reset is held, even with PIX_DIV=1.
  assign pix_ce    = rst_n && en && (div_cnt == DIV_LAST);
  assign line_end  = pix_ce && (hpos == H_LAST);
  assign frame_end = line_end && (vpos == V_LAST);

  // Next-state counters; restart wins over any wrap so frame never bumps.
  always_comb begin
    div_nxt = div_cnt;
    h_nxt   = hpos;
    v_nxt   = vpos;
    f_nxt   = frame;
    if (restart) begin
      div_nxt = '0;
      h_nxt   = '0;
      v_nxt   = '0;
    end else if (en) begin
      if (pix_ce) begin
        div_nxt = '0;
        if (hpos == H_LAST) begin
          h_nxt = '0;
          if (vpos == V_LAST) begin
            v_nxt = '0;
            f_nxt = frame + FRAME_W'(1);
          end else begin
            v_nxt = vpos + POS_W'(1);
          end
        end else begin
          h_nxt = hpos + POS_W'(1);
        end
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
    end
  end

  // Syncs and blanking are decoded from the next position so they line up with hpos/vpos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      hpos       <= '0;
      vpos       <= '0;
      frame      <= '0;
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      display_on <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      hpos    <= h_nxt;
      vpos    <= v_nxt;
      frame   <= f_nxt;
      if (restart) begin
        hsync      <= ~HS_POL;
        vsync      <= ~VS_POL;
        display_on <= 1'b1;
      end else begin
        hsync      <= in_span(h_nxt, HS_START, H_SYNC) ? HS_POL : ~HS_POL;
        vsync      <= in_span(v_nxt, VS_START, V_SYNC) ? VS_POL : ~VS_POL;
        display_on <= (h_nxt < POS_W'(H_DISPLAY)) && (v_nxt < POS_W'(V_DISPLAY));
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed table, hand corner sequences, random run
// against an arithmetic raster model, and a default 640x480 line check.
module tb_video_timing_gen;

  localparam int unsigned PW = 10;
  localparam int unsigned FW = 3;
  localparam int HT = 14, VT = 8, DIV = 2, FR = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, restart;
  logic [PW-1:0] hpos, vpos;
  logic hsync, vsync, display_on, pix_ce, line_end, frame_end;
  logic [FW-1:0] frame;

  logic rst2_n, en2, restart2;
  logic [9:0] hpos2, vpos2;
  logic hsync2, vsync2, de2, ce2, le2, fe2;
  logic [19:0] frame2;

  video_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIX_DIV(2), .POS_W(PW), .FRAME_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .pix_ce(pix_ce), .line_end(line_end),
    .frame_end(frame_end), .frame(frame)
  );

  video_timing_gen dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .restart(restart2),
    .hpos(hpos2), .vpos(vpos2), .hsync(hsync2), .vsync(vsync2),
    .display_on(de2), .pix_ce(ce2), .line_end(le2),
    .frame_end(fe2), .frame(frame2)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: q = enabled clk edges since reset/restart; everything follows by division.
  int q = 0;
  int base = 0;

  function automatic int m_frame();
    return (base + (q / DIV) / FR) % (1 << FW);
  endfunction

  task automatic check_model(input string tag);
    int p, h, v, ce, le, fe;
    p  = q / DIV;
    h  = p % HT;
    v  = (p / HT) % VT;
    ce = (rst_n && en && (q % DIV == DIV - 1)) ? 1 : 0;
    le = (ce && h == HT - 1) ? 1 : 0;
    fe = (le && v == VT - 1) ? 1 : 0;
    chk({tag, ".hpos"}, int'(hpos), h);
    chk({tag, ".vpos"}, int'(vpos), v);
    chk({tag, ".hsync"}, int'(hsync), (h >= 10 && h <= 12) ? 0 : 1);
    chk({tag, ".vsync"}, int'(vsync), (v >= 5 && v <= 6) ? 1 : 0);
    chk({tag, ".display_on"}, int'(display_on), (h < 8 && v < 4) ? 1 : 0);
    chk({tag, ".pix_ce"}, int'(pix_ce), ce);
    chk({tag, ".line_end"}, int'(line_end), le);
    chk({tag, ".frame_end"}, int'(frame_end), fe);
    chk({tag, ".frame"}, int'(frame), m_frame());
  endtask

  typedef struct {
    bit en; bit rs; int n;
    int h; int v; bit hs; bit vs; bit de; bit ce; bit le;
  } vec_t;

  vec_t tbl[12];

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
  endtask

  initial begin
    int le_cnt, fe_cnt, fe_h, fe_v, hs_low, le_first, le_second;
    string tag;

    tbl[0]  = '{1'b1, 1'b0, 0,  0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1,  0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1,  1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10, 6, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5,  6, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2,  7, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 7, 10, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 5, 13, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1, 13, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8,  3, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1,  0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1,  0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; en = 1'b0; restart = 1'b0;
    rst2_n = 1'b0; en2 = 1'b1; restart2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.hpos", int'(hpos), 0);
    chk("rst.hsync", int'(hsync), 1);
    chk("rst.vsync", int'(vsync), 0);
    chk("rst.pix_ce2", int'(ce2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en;
      restart = tbl[i].rs;
      run(tbl[i].n);
      tag = $sformatf("tbl%0d", i);
      chk({tag, ".hpos"}, int'(hpos), tbl[i].h);
      chk({tag, ".vpos"}, int'(vpos), tbl[i].v);
      chk({tag, ".hsync"}, int'(hsync), int'(tbl[i].hs));
      chk({tag, ".vsync"}, int'(vsync), int'(tbl[i].vs));
      chk({tag, ".display_on"}, int'(display_on), int'(tbl[i].de));
      chk({tag, ".pix_ce"}, int'(pix_ce), int'(tbl[i].ce));
      chk({tag, ".line_end"}, int'(line_end), int'(tbl[i].le));
      chk({tag, ".frame"}, int'(frame), 0);
    end
    restart = 1'b0;
    en = 1'b1;

    // One full frame of strobes from the post-restart state.
    le_cnt = 0; fe_cnt = 0; fe_h = -1; fe_v = -1;
    for (int i = 0; i < HT * VT * DIV; i++) begin
      run(1);
      le_cnt += int'(line_end);
      fe_cnt += int'(frame_end);
      if (frame_end) begin
        fe_h = int'(hpos);
        fe_v = int'(vpos);
      end
    end
    chk("frm.line_end_count", le_cnt, 8);
    chk("frm.frame_end_count", fe_cnt, 1);
    chk("frm.frame_end_hpos", fe_h, 13);
    chk("frm.frame_end_vpos", fe_v, 7);
    chk("frm.frame", int'(frame), 1);

    // Restart landing on a frame_end cycle must not bump frame.
    run(222);
    chk("rsf.frame_end", int'(frame_end), 1);
    chk("rsf.frame_before", int'(frame), 1);
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    chk("rsf.hpos", int'(hpos), 0);
    chk("rsf.vpos", int'(vpos), 0);
    chk("rsf.frame_after", int'(frame), 1);

    // Asynchronous reset mid-line with no clock edge.
    run(90);
    chk("arst.pre_vpos", int'(vpos), 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.hpos", int'(hpos), 0);
    chk("arst.vpos", int'(vpos), 0);
    chk("arst.frame", int'(frame), 0);
    chk("arst.hsync", int'(hsync), 1);
    chk("arst.vsync", int'(vsync), 0);
    chk("arst.display_on", int'(display_on), 1);
    chk("arst.pix_ce", int'(pix_ce), 0);
    q = 0; base = 0;

    // Randomized run against the model.
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      en = ($urandom_range(99) < 85);
      restart = ($urandom_range(499) == 0);
      rst_n = ($urandom_range(1999) != 0);
      if (!rst_n) begin
        q = 0;
        base = 0;
      end
      #1;
      check_model("rnd");
      @(posedge clk);
      if (rst_n) begin
        if (restart) begin
          base = m_frame();
          q = 0;
        end else if (en) begin
          q++;
        end
      end
    end

    // Default 640x480, PIX_DIV=1: 800-clk lines with 96 clks of hsync low.
    @(negedge clk);
    rst2_n = 1'b1;
    hs_low = 0; le_first = -1; le_second = -1;
    for (int i = 0; i < 1600; i++) begin
      #1;
      if (i < 800 && !hsync2) hs_low++;
      if (le2) begin
        if (le_first < 0) le_first = i;
        else if (le_second < 0) le_second = i;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("vga.hsync_low", hs_low, 96);
    chk("vga.line_end_first", le_first, 799);
    chk("vga.line_period", le_second - le_first, 800);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
